count_game_ctrl: RTL

Game controller for the counting game; sits directly upstream of the 8x8 dot-matrix display driver. It debounces two push-buttons, runs a start/pause/restart state machine, and counts a 3-bit value down from 7 to 0 at one step per tick period. It drives the display's `num` value and `st` enable, and flags completion.

---
 rtl/count_game_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/count_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : count_game_ctrl
// Brief    : Counting-game controller: key debounce, start/pause FSM, 7..0
//            countdown driving the dot-matrix display num/st inputs.
// Revision : 1.0 - initial release
// ============================================================================
module count_game_ctrl #(
    parameter int TICK_DIV   = 1000,
    parameter int DEB_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_pause,
    output logic [2:0] num,
    output logic       st,
    output logic       done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    logic [1:0] key_raw;
    logic [1:0] key_press;

    assign key_raw = {key_pause, key_start};

    // Index 0 is the start key, index 1 the pause key.
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic          sync1_q, sync1_d;
        logic          sync2_q, sync2_d;
        logic          deb_q, deb_d;
        logic          deb_dly_q, deb_dly_d;
        logic [DW-1:0] dcnt_q, dcnt_d;

        always_comb begin
            sync1_d   = key_raw[k];
            sync2_d   = sync1_q;
            deb_dly_d = deb_q;
            deb_d     = deb_q;
            dcnt_d    = '0;
            if (sync2_q != deb_q) begin
                if (dcnt_q == DEB_LAST) begin
                    deb_d = ~deb_q;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                deb_q     <= 1'b0;
                deb_dly_q <= 1'b0;
                dcnt_q    <= '0;
            end else begin
                sync1_q   <= sync1_d;
                sync2_q   <= sync2_d;
                deb_q     <= deb_d;
                deb_dly_q <= deb_dly_d;
                dcnt_q    <= dcnt_d;
            end
        end

        assign key_press[k] = deb_q & ~deb_dly_q;
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    num_q, num_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          st_q, st_d;
    logic          done_q, done_d;
    logic          start_ev, pause_ev, tick;

    assign start_ev = key_press[0];
    assign pause_ev = key_press[1];
    assign tick     = (tcnt_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        tcnt_d  = tcnt_q;
        st_d    = st_q;
        done_d  = done_q;
        // Start outranks everything, including a tick on the same edge.
        if (start_ev) begin
            state_d = S_RUN;
            num_d   = 3'd7;
            tcnt_d  = '0;
            st_d    = 1'b1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    tcnt_d = tick ? '0 : tcnt_q + TW'(1);
                    if (tick && (num_q != 3'd0)) begin
                        num_d = num_q - 3'd1;
                    end
                    // The final tick finishes the count even if pause arrives with it.
                    if (tick && (num_q == 3'd1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (pause_ev) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (pause_ev) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            num_q   <= 3'd7;
            tcnt_q  <= '0;
            st_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            tcnt_q  <= tcnt_d;
            st_q    <= st_d;
            done_q  <= done_d;
        end
    end

    assign num  = num_q;
    assign st   = st_q;
    assign done = done_q;

endmodule
`default_nettype wire
